soc_or1k_tap_scheduler: RTL and testbench
=========================================

// Module: soc_or1k_tap_scheduler
// PURPOSE
//  Shares a single TAP result channel between NUM_REQ concurrent checkers in a
//  Wishbone SoC bench. Requests are granted round-robin and registered into one
//  output stage. Each result gets a 1-based testcase index for the TAP writer task.
//  Pass/fail tallies are kept, and the test plan is closed with done once NUM_TESTS
//  results are delivered.
// PARAMETERS
//  NUM_REQ    4   number of requesting checkers (>=1)
//  NUM_TESTS  16  planned testcase count; 0 = unlimited (done never asserts)
//  ID_WIDTH   8   per-request test identifier width
//  CNT_WIDTH  16  width of index and tally counters
// PORTS
//  clk        in   1                 clock, rising edge
//  rst_n      in   1                 asynchronous active-low reset
//  req_valid  in   NUM_REQ           checker i has a result pending
//  req_ok     in   NUM_REQ           result of checker i (1 = ok, 0 = not ok)
//  req_id     in   NUM_REQ*ID_WIDTH  test id of checker i, slice [i*ID_WIDTH +: ID_WIDTH]
//  req_ready  out  NUM_REQ           one-hot accept; a transfer happens when valid&ready
//  tc_valid   out  1                 registered result available
//  tc_ready   in   1                 TAP writer consumes the result
//  tc_ok      out  1                 ok/not-ok of the presented result
//  tc_src     out  $clog2(NUM_REQ)   granted requester index (1 bit min)
//  tc_id      out  ID_WIDTH          test id of the presented result
//  tc_index   out  CNT_WIDTH         1-based testcase number of the presented result
//  pass_cnt   out  CNT_WIDTH         delivered ok results, saturating
//  fail_cnt   out  CNT_WIDTH         delivered not-ok results, saturating
//  done       out  1                 plan complete, sticky until reset
//  overflow   out  1                 result accepted after done, sticky
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - All outputs 0, including req_ready and tc_*.
//   - Round-robin pointer = 0; state = IDLE; internal accepted-count = 0.
//  States:
//   - IDLE: output register empty.
//   - FULL: tc_valid=1.
//   - DONE: plan closed.
//  Slot free = IDLE, or FULL with tc_valid&tc_ready in the same cycle.
//  Arbitration (combinational):
//   - When the slot is free and state!=DONE, grant the first asserted req_valid at
//     or after the pointer, wrapping modulo NUM_REQ.
//   - req_ready is one-hot on the granted requester and 0 otherwise.
//   - req_ready never asserts for a requester with req_valid=0.
//  Accept at edge N: tc_* loaded and tc_valid=1 at N+1 (latency 1). Also:
//   - tc_index = accepted-count+1; accepted-count increments.
//   - Pointer moves to granted index+1, wrapping.
//  Throughput: 1 result/cycle while tc_ready stays high (drain and refill same edge).
//  Backpressure: with tc_valid=1 and tc_ready=0, tc_* stay stable and req_ready=0.
//  Tallies update on the tc handshake, not on accept:
//   - ok -> pass_cnt+1; not ok -> fail_cnt+1.
//   - Both saturate at all-ones.
//  Plan close: the handshake that delivers tc_index==NUM_TESTS (NUM_TESTS!=0) moves
//   the state to DONE. From the next cycle: done=1 and tc_valid=0. No new grant is
//   made in that handshake cycle once accepted-count==NUM_TESTS.
//  DONE state:
//   - Requests are still granted round-robin, one per cycle, so checkers do not hang.
//   - Granted results are dropped and overflow is set at the next edge.
//   - Counters and tc_* are unchanged.
//  Reset mid-operation: the pending result is discarded; no partial state is kept.
//  NUM_REQ=1: pointer is fixed at 0; tc_src is 1 bit wide and always 0.
// TESTING
//  1. Reset with req_valid=4'b1111 -> all outputs 0 while rst_n=0. First grant
//     after release is req 0; tc_index=1 one cycle later.
//  2. req_valid=4'b1111 held, tc_ready=1 -> grants 0,1,2,3,0 on consecutive cycles;
//     tc_index 1..5 and tc_src 0,1,2,3,0.
//  3. tc_ready=0 for 3 cycles with tc_valid=1 -> tc_* stable and req_ready=0. Then
//     tc_ready=1 -> one handshake per cycle resumes with no loss or duplicate.
//  4. NUM_TESTS=4, ok pattern 1,0,1,1 -> pass_cnt=3 and fail_cnt=1; done=1 the cycle
//     after the 4th handshake; tc_valid=0 after that.
//  5. After done, req_valid[2]=1 -> req_ready[2]=1 and overflow=1 next cycle; pass_cnt,
//     fail_cnt and tc_index unchanged.
//  6. rst_n low while tc_valid=1 and tc_ready=0 -> pending result lost. After release,
//     tc_index restarts at 1 and tallies at 0.

Source files
------------

// File: rtl/soc_or1k_tap_scheduler.sv
// Round-robin scheduler that shares one registered TAP result slot between
// NUM_REQ checkers, numbers each result, keeps pass/fail tallies and closes
// the test plan after NUM_TESTS delivered results.
module soc_or1k_tap_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_TESTS = 16,
  parameter int ID_WIDTH  = 8,
  parameter int CNT_WIDTH = 16,
  localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_ok,
  input  logic [NUM_REQ*ID_WIDTH-1:0] req_id,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tc_valid,
  input  logic                        tc_ready,
  output logic                        tc_ok,
  output logic [SRC_W-1:0]            tc_src,
  output logic [ID_WIDTH-1:0]         tc_id,
  output logic [CNT_WIDTH-1:0]        tc_index,
  output logic [CNT_WIDTH-1:0]        pass_cnt,
  output logic [CNT_WIDTH-1:0]        fail_cnt,
  output logic                        done,
  output logic                        overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FULL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam bit                   HAS_PLAN  = (NUM_TESTS != 0);
  localparam logic [CNT_WIDTH-1:0] PLAN_LAST = CNT_WIDTH'(NUM_TESTS);

  state_t                state_reg, state_next;
  logic [SRC_W-1:0]      ptr_reg, ptr_next;
  logic [CNT_WIDTH-1:0]  acc_cnt_reg;
  logic                  tc_ok_reg;
  logic [SRC_W-1:0]      tc_src_reg;
  logic [ID_WIDTH-1:0]   tc_id_reg;
  logic [CNT_WIDTH-1:0]  tc_index_reg;
  logic [CNT_WIDTH-1:0]  pass_cnt_reg;
  logic [CNT_WIDTH-1:0]  fail_cnt_reg;
  logic                  overflow_reg;

  logic [ID_WIDTH-1:0]   id_slice [NUM_REQ];
  logic                  handshake;
  logic                  slot_free;
  logic                  limit_hit;
  logic                  grant_en;
  logic                  grant_found;
  logic [SRC_W-1:0]      grant_idx;
  logic                  grant;
  logic                  accept;
  logic                  drop;
  logic [SRC_W-1:0]      cand_idx;
  int                    cand_sum;

  // Per-requester id slices and the one-hot ready vector. Ready is forced low
  // while reset is held so checkers never see an accept during reset.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign id_slice[gi]  = req_id[gi*ID_WIDTH +: ID_WIDTH];
    assign req_ready[gi] = rst_n & grant & (grant_idx == SRC_W'(gi));
  end

  assign handshake = (state_reg == ST_FULL) && tc_ready;
  assign slot_free = (state_reg == ST_IDLE) || handshake;
  // The result currently held is the last planned one: no further real grants.
  assign limit_hit = HAS_PLAN && (acc_cnt_reg == PLAN_LAST);
  // After the plan closes requests are still drained so checkers never stall.
  assign grant_en  = (state_reg == ST_DONE) || (slot_free && !limit_hit);
  assign grant     = grant_en && grant_found;
  assign accept    = grant && (state_reg != ST_DONE);
  assign drop      = grant && (state_reg == ST_DONE);

  // Round-robin search: first asserted request at or after the pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = 0;
    cand_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = int'(ptr_reg) + i;
      if (cand_sum >= NUM_REQ) begin
        cand_sum = cand_sum - NUM_REQ;
      end
      cand_idx = SRC_W'(cand_sum);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Pointer advances past the granted requester, wrapping at NUM_REQ.
  always_comb begin
    ptr_next = ptr_reg;
    if (grant) begin
      ptr_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // Next-state logic for the output slot.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = ST_FULL;
      end
      ST_FULL: begin
        if (handshake) begin
          if (limit_hit)   state_next = ST_DONE;
          else if (accept) state_next = ST_FULL;
          else             state_next = ST_IDLE;
        end
      end
      ST_DONE: state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Output slot, pointer, accepted count, tallies and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg      <= '0;
      acc_cnt_reg  <= '0;
      tc_ok_reg    <= 1'b0;
      tc_src_reg   <= '0;
      tc_id_reg    <= '0;
      tc_index_reg <= '0;
      pass_cnt_reg <= '0;
      fail_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
      if (accept) begin
        acc_cnt_reg  <= acc_cnt_reg + 1'b1;
        tc_ok_reg    <= req_ok[grant_idx];
        tc_src_reg   <= grant_idx;
        tc_id_reg    <= id_slice[grant_idx];
        tc_index_reg <= acc_cnt_reg + 1'b1;
      end
      if (handshake) begin
        if (tc_ok_reg) begin
          if (pass_cnt_reg != '1) pass_cnt_reg <= pass_cnt_reg + 1'b1;
        end else begin
          if (fail_cnt_reg != '1) fail_cnt_reg <= fail_cnt_reg + 1'b1;
        end
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign tc_valid = (state_reg == ST_FULL);
  assign done     = (state_reg == ST_DONE);
  assign tc_ok    = tc_ok_reg;
  assign tc_src   = tc_src_reg;
  assign tc_id    = tc_id_reg;
  assign tc_index = tc_index_reg;
  assign pass_cnt = pass_cnt_reg;
  assign fail_cnt = fail_cnt_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_soc_or1k_tap_scheduler.sv
// Testbench for soc_or1k_tap_scheduler: directed scenarios on two instances
// (16-test and 4-test plans) plus randomized traffic against a reference model.
module tb_soc_or1k_tap_scheduler;

  localparam int NT_A = 16;
  localparam int NT_B = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ok;
  logic [31:0] req_id;
  logic        tc_ready;

  logic [3:0]  a_req_ready, b_req_ready;
  logic        a_tc_valid, b_tc_valid, a_tc_ok, b_tc_ok;
  logic [1:0]  a_tc_src, b_tc_src;
  logic [7:0]  a_tc_id, b_tc_id;
  logic [15:0] a_tc_index, b_tc_index, a_pass, b_pass, a_fail, b_fail;
  logic        a_done, b_done, a_overflow, b_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  soc_or1k_tap_scheduler #(.NUM_REQ(4), .NUM_TESTS(NT_A), .ID_WIDTH(8), .CNT_WIDTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ok(req_ok), .req_id(req_id),
    .req_ready(a_req_ready), .tc_valid(a_tc_valid), .tc_ready(tc_ready), .tc_ok(a_tc_ok),
    .tc_src(a_tc_src), .tc_id(a_tc_id), .tc_index(a_tc_index), .pass_cnt(a_pass),
    .fail_cnt(a_fail), .done(a_done), .overflow(a_overflow));

  soc_or1k_tap_scheduler #(.NUM_REQ(4), .NUM_TESTS(NT_B), .ID_WIDTH(8), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ok(req_ok), .req_id(req_id),
    .req_ready(b_req_ready), .tc_valid(b_tc_valid), .tc_ready(tc_ready), .tc_ok(b_tc_ok),
    .tc_src(b_tc_src), .tc_id(b_tc_id), .tc_index(b_tc_index), .pass_cnt(b_pass),
    .fail_cnt(b_fail), .done(b_done), .overflow(b_overflow));

  // Holds reset for two cycles with every requester asserting; returns at a
  // falling edge with rst_n still low.
  task automatic hold_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_ok    = 4'h0;
    req_id    = 32'hA3A2A1A0;
    tc_ready  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    hold_reset();
    #1;
    n_checks++;
    if ({a_req_ready, b_req_ready} !== 8'h00) begin
      n_fail++; $display("FAIL reset_req_ready: got %b/%b want 0000/0000", a_req_ready, b_req_ready);
    end
    n_checks++;
    if ({a_tc_valid, a_tc_ok, a_tc_src, a_tc_id, a_tc_index, a_pass, a_fail, a_done, a_overflow} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: valid=%b idx=%0d pass=%0d fail=%0d done=%b ovf=%b want all 0",
                         a_tc_valid, a_tc_index, a_pass, a_fail, a_done, a_overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (a_req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL reset_first_grant: got %b want 0001", a_req_ready);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({a_tc_valid, a_tc_src, a_tc_id, a_tc_index} !== {1'b1, 2'd0, 8'hA0, 16'd1}) begin
      n_fail++; $display("FAIL reset_first_result: valid=%b src=%0d id=%h idx=%0d want 1/0/a0/1",
                         a_tc_valid, a_tc_src, a_tc_id, a_tc_index);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    hold_reset();
    rst_n    = 1'b1;
    tc_ready = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      #1;
      exp_rdy = 4'(1 << (k % 4));
      n_checks++;
      if (a_req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, a_req_ready, exp_rdy);
      end
      if (k > 0) begin
        n_checks++;
        if ({a_tc_valid, a_tc_src, a_tc_id, a_tc_index} !== {1'b1, 2'((k-1) % 4), 8'(8'hA0 + (k-1) % 4), 16'(k)}) begin
          n_fail++; $display("FAIL rr_result[%0d]: valid=%b src=%0d id=%h idx=%0d want 1/%0d/%h/%0d",
                             k, a_tc_valid, a_tc_src, a_tc_id, a_tc_index, (k-1) % 4, 8'hA0 + (k-1) % 4, k);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    hold_reset();
    rst_n  = 1'b1;
    req_ok = 4'b1010;
    #1;
    n_checks++;
    if (a_req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL bp_first_grant: got %b want 0001", a_req_ready);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if ({a_tc_valid, a_tc_ok, a_tc_src, a_tc_id, a_tc_index, a_req_ready} !== {1'b1, 1'b0, 2'd0, 8'hA0, 16'd1, 4'b0000}) begin
        n_fail++; $display("FAIL bp_stall[%0d]: valid=%b ok=%b src=%0d id=%h idx=%0d rdy=%b want 1/0/0/a0/1/0000",
                           k, a_tc_valid, a_tc_ok, a_tc_src, a_tc_id, a_tc_index, a_req_ready);
      end
      @(negedge clk);
    end
    tc_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      n_checks++;
      if ({a_req_ready, a_tc_valid, a_tc_ok, a_tc_src, a_tc_index} !==
          {4'(1 << (k % 4)), 1'b1, 1'(((k-1) % 2) == 1), 2'(k-1), 16'(k)}) begin
        n_fail++; $display("FAIL bp_resume[%0d]: rdy=%b valid=%b ok=%b src=%0d idx=%0d want %b/1/%0d/%0d/%0d",
                           k, a_req_ready, a_tc_valid, a_tc_ok, a_tc_src, a_tc_index,
                           4'(1 << (k % 4)), (k-1) % 2, k-1, k);
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if ({a_pass, a_fail} !== {16'd2, 16'd2}) begin
      n_fail++; $display("FAIL bp_tally: pass=%0d fail=%0d want 2/2", a_pass, a_fail);
    end
  endtask

  task automatic test_plan_close();
    hold_reset();
    rst_n    = 1'b1;
    req_ok   = 4'b1101;
    tc_ready = 1'b1;
    #1;
    n_checks++;
    if (b_req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL plan_first_grant: got %b want 0001", b_req_ready);
    end
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if ({b_req_ready, b_tc_valid, b_tc_index} !== {4'b0000, 1'b1, 16'd4}) begin
      n_fail++; $display("FAIL plan_last_nogrant: rdy=%b valid=%b idx=%0d want 0000/1/4",
                         b_req_ready, b_tc_valid, b_tc_index);
    end
    req_valid = 4'h0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({b_done, b_tc_valid, b_pass, b_fail, b_overflow} !== {1'b1, 1'b0, 16'd3, 16'd1, 1'b0}) begin
      n_fail++; $display("FAIL plan_done: done=%b valid=%b pass=%0d fail=%0d ovf=%b want 1/0/3/1/0",
                         b_done, b_tc_valid, b_pass, b_fail, b_overflow);
    end
  endtask

  // Continues from test_plan_close with instance B in the closed state.
  task automatic test_overflow();
    req_valid = 4'b0100;
    #1;
    n_checks++;
    if (b_req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL ovf_grant: got %b want 0100", b_req_ready);
    end
    @(negedge clk);
    req_valid = 4'h0;
    #1;
    n_checks++;
    if ({b_overflow, b_done, b_tc_valid, b_pass, b_fail, b_tc_index} !== {1'b1, 1'b1, 1'b0, 16'd3, 16'd1, 16'd4}) begin
      n_fail++; $display("FAIL ovf_state: ovf=%b done=%b valid=%b pass=%0d fail=%0d idx=%0d want 1/1/0/3/1/4",
                         b_overflow, b_done, b_tc_valid, b_pass, b_fail, b_tc_index);
    end
    req_valid = 4'hF;
    #1;
    n_checks++;
    if (b_req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL ovf_rr0: got %b want 1000", b_req_ready);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (b_req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL ovf_rr1: got %b want 0001", b_req_ready);
    end
    req_valid = 4'h0;
  endtask

  task automatic test_reset_mid();
    hold_reset();
    rst_n    = 1'b1;
    tc_ready = 1'b1;
    repeat (3) @(negedge clk);
    tc_ready = 1'b0;
    #1;
    n_checks++;
    if ({a_tc_valid, a_tc_index, a_fail} !== {1'b1, 16'd3, 16'd2}) begin
      n_fail++; $display("FAIL mid_prereset: valid=%b idx=%0d fail=%0d want 1/3/2", a_tc_valid, a_tc_index, a_fail);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_tc_valid, a_req_ready, a_fail, a_tc_index} !== '0) begin
      n_fail++; $display("FAIL mid_in_reset: valid=%b rdy=%b fail=%0d idx=%0d want 0", a_tc_valid, a_req_ready, a_fail, a_tc_index);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    req_ok   = 4'hF;
    tc_ready = 1'b1;
    #1;
    n_checks++;
    if (a_req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL mid_regrant: got %b want 0001", a_req_ready);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({a_tc_valid, a_tc_index, a_pass, a_fail} !== {1'b1, 16'd1, 16'd0, 16'd0}) begin
      n_fail++; $display("FAIL mid_restart: valid=%b idx=%0d pass=%0d fail=%0d want 1/1/0/0", a_tc_valid, a_tc_index, a_pass, a_fail);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({a_pass, a_tc_index} !== {16'd1, 16'd2}) begin
      n_fail++; $display("FAIL mid_after: pass=%0d idx=%0d want 1/2", a_pass, a_tc_index);
    end
  endtask

  // Random traffic on instance A. The model tracks the plan as a set of
  // counters and a single held result; it is stepped once per clock.
  task automatic test_random(input int phases, input int cycles);
    int ptr, acc, pass, fail, s_src, s_idx, gidx, j;
    bit sv, s_ok, dn, ovf, hs, was_done, allow;
    logic [7:0] s_id;
    logic [3:0] exp_rdy;
    for (int p = 0; p < phases; p++) begin
      hold_reset();
      rst_n = 1'b1;
      ptr = 0; acc = 0; pass = 0; fail = 0; s_src = 0; s_idx = 0;
      sv = 0; s_ok = 0; dn = 0; ovf = 0; s_id = '0;
      for (int c = 0; c < cycles; c++) begin
        req_valid = (p == 1) ? 4'($urandom & $urandom) : 4'($urandom);
        req_ok    = 4'($urandom);
        req_id    = $urandom;
        tc_ready  = ($urandom_range(0, 3) != 0);
        #1;
        allow = dn || ((!sv || tc_ready) && acc != NT_A);
        gidx  = -1;
        if (allow) begin
          for (int k = 0; k < 4; k++) begin
            j = (ptr + k) % 4;
            if (gidx < 0 && ((req_valid >> j) & 4'd1) != 4'd0) gidx = j;
          end
        end
        exp_rdy = (gidx >= 0) ? 4'(1 << gidx) : 4'b0000;
        n_checks++;
        if (a_req_ready !== exp_rdy) begin
          n_fail++; $display("FAIL rnd_ready p%0d c%0d: got %b want %b", p, c, a_req_ready, exp_rdy);
        end
        n_checks++;
        if (a_tc_valid !== sv) begin
          n_fail++; $display("FAIL rnd_valid p%0d c%0d: got %b want %b", p, c, a_tc_valid, sv);
        end
        if (sv) begin
          n_checks++;
          if ({a_tc_ok, a_tc_src, a_tc_id, a_tc_index} !== {s_ok, 2'(s_src), s_id, 16'(s_idx)}) begin
            n_fail++; $display("FAIL rnd_payload p%0d c%0d: ok=%b src=%0d id=%h idx=%0d want %b/%0d/%h/%0d",
                               p, c, a_tc_ok, a_tc_src, a_tc_id, a_tc_index, s_ok, s_src, s_id, s_idx);
          end
        end
        n_checks++;
        if ({a_pass, a_fail, a_done, a_overflow} !== {16'(pass), 16'(fail), dn, ovf}) begin
          n_fail++; $display("FAIL rnd_status p%0d c%0d: pass=%0d fail=%0d done=%b ovf=%b want %0d/%0d/%b/%b",
                             p, c, a_pass, a_fail, a_done, a_overflow, pass, fail, dn, ovf);
        end
        hs       = sv && tc_ready;
        was_done = dn;
        if (hs) begin
          if (s_ok) pass++; else fail++;
          sv = 0;
          if (s_idx == NT_A) dn = 1;
        end
        if (gidx >= 0) begin
          ptr = (gidx + 1) % 4;
          if (was_done) begin
            ovf = 1;
          end else begin
            acc++;
            sv    = 1;
            s_ok  = ((req_ok >> gidx) & 4'd1) != 4'd0;
            s_src = gidx;
            s_id  = 8'(req_id >> (8 * gidx));
            s_idx = acc;
          end
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'h0;
    req_ok    = 4'h0;
    req_id    = 32'h0;
    tc_ready  = 1'b0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_plan_close();
    test_overflow();
    test_reset_mid();
    test_random(3, 80);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
